countdown_timer_p: RTL and testbench

- Parametrised successor to the team's fixed 30 s countdown.
- Single system-clock domain; advanced by a 1-cycle `tick` strobe from the shared prescaler, not by a derived clock.
- Adds runtime-loadable start value, start/pause control, a sticky expiry flag and a bounded buzzer pulse.
- Sits between the 1 Hz prescaler and the seven-segment driver / buzzer pin in the top level.

---
 rtl/countdown_timer_p.sv | 121 ++++++++++++
 tb/tb_countdown_timer_p.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_p.sv
// Countdown timer: tick-driven count with start/pause, sticky expiry flag and a bounded buzzer pulse.
// Optional periodic alarm enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
module countdown_timer_p #(
  parameter int WIDTH        = 5,
  parameter int DEFAULT_LOAD = 30,
  parameter int BUZZ_CYCLES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] remaining,
  output logic             running,
  output logic             expired,
  output logic             buzz
);

  localparam int CW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [CW-1:0]    BUZZ_LAST = CW'(BUZZ_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] LOAD_INIT = WIDTH'(DEFAULT_LOAD);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO      = '0;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] PAUSED = 3'd2;
  localparam logic [2:0] ALERT  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] buzz_cnt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  assign running = (state == RUN);

  // buzz_cnt holds the number of buzz cycles already shown, so entry sets it to 1
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= LOAD_INIT;
      expired   <= 1'b0;
      buzz      <= 1'b0;
      buzz_cnt  <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload    <= LOAD_INIT;
`endif
    end else if (load) begin
      state     <= IDLE;
      remaining <= load_val;
      expired   <= 1'b0;
      buzz      <= 1'b0;
      buzz_cnt  <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload    <= load_val;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && !pause) begin
            if (remaining != ZERO) begin
              state <= RUN;
            end else begin
              state    <= ALERT;
              expired  <= 1'b1;
              buzz     <= 1'b1;
              buzz_cnt <= CNT_ONE;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state <= PAUSED;
          end else if (tick) begin
            if (remaining > ONE) begin
              remaining <= remaining - ONE;
            end else if (remaining == ONE) begin
              remaining <= ZERO;
              state     <= ALERT;
              expired   <= 1'b1;
              buzz      <= 1'b1;
              buzz_cnt  <= CNT_ONE;
            end
          end
        end
        PAUSED: begin
          if (start && !pause) state <= RUN;
        end
        ALERT: begin
          if (buzz_cnt >= BUZZ_LAST) begin
            buzz     <= 1'b0;
            buzz_cnt <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            // Periodic alarm: restart from the last loaded value; expired stays set
            if (reload != ZERO) begin
              remaining <= reload;
              state     <= RUN;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end else begin
            buzz_cnt <= buzz_cnt + CNT_ONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_p.sv
// Self-checking bench for countdown_timer_p: vector table plus hand-written corner sequences.
// Expected values adapt when COUNTDOWN_AUTO_RELOAD_EN is defined.
module tb_countdown_timer_p;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       tick;
  logic       load;
  logic [4:0] load_val;
  logic       start;
  logic       pause;
  logic [4:0] remaining;
  logic       running;
  logic       expired;
  logic       buzz;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic       rst_v;
    logic       load_v;
    logic [4:0] load_val_v;
    logic       start_v;
    logic       pause_v;
    logic       tick_v;
    int         exp_rem;
    logic       exp_run;
    logic       exp_exp;
    logic       exp_buzz;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[$];

  countdown_timer_p #(.WIDTH(5), .DEFAULT_LOAD(30), .BUZZ_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .remaining(remaining), .running(running),
    .expired(expired), .buzz(buzz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, bit r, bit l, int lv, bit s, bit p, bit t,
                              int er, bit erun, bit eexp, bit ebuzz);
    vec_t v;
    v.name = n; v.rst_v = r; v.load_v = l; v.load_val_v = 5'(lv);
    v.start_v = s; v.pause_v = p; v.tick_v = t;
    v.exp_rem = er; v.exp_run = erun; v.exp_exp = eexp; v.exp_buzz = ebuzz;
    return v;
  endfunction

  task automatic compare(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, required);
    end
  endtask

  task automatic check_output();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, want one entry");
    end else begin
      e = exp_q.pop_front();
      compare({e.name, ".remaining"}, int'(remaining), e.exp_rem);
      compare({e.name, ".running"}, int'(running), int'(e.exp_run));
      compare({e.name, ".expired"}, int'(expired), int'(e.exp_exp));
      compare({e.name, ".buzz"}, int'(buzz), int'(e.exp_buzz));
    end
  endtask

  // Drive away from the active edge, then sample 1 time unit after it
  task automatic apply_stimulus(vec_t v);
    @(negedge clk);
    rst = v.rst_v; load = v.load_v; load_val = v.load_val_v;
    start = v.start_v; pause = v.pause_v; tick = v.tick_v;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;

    apply_stimulus(mk("reset", 0, 0, 0, 0, 0, 0, 30, 0, 0, 0));
    apply_stimulus(mk("idle_tick", 1, 0, 0, 0, 0, 1, 30, 0, 0, 0));
    apply_stimulus(mk("start30", 1, 0, 0, 1, 0, 0, 30, 1, 0, 0));
    for (int i = 1; i <= 30; i++)
      apply_stimulus(mk("tick_down", 1, 0, 0, 0, 0, 1, 30 - i, i < 30, i == 30, i == 30));
    apply_stimulus(mk("buzz_hold1", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    apply_stimulus(mk("buzz_hold2", 1, 0, 0, 1, 0, 1, 0, 0, 1, 1));
    apply_stimulus(mk("buzz_end", 1, 0, 0, 0, 0, 0, AUTO ? 30 : 0, AUTO, 1, 0));
    for (int k = 1; k <= 5; k++)
      apply_stimulus(mk("after_done", 1, 0, 0, 0, 0, 1, AUTO ? 30 - k : 0, AUTO, 1, 0));

    vecs.push_back(mk("load7", 1, 1, 7, 0, 0, 0, 7, 0, 0, 0));
    vecs.push_back(mk("start7", 1, 0, 0, 1, 0, 0, 7, 1, 0, 0));
    vecs.push_back(mk("t7a", 1, 0, 0, 0, 0, 1, 6, 1, 0, 0));
    vecs.push_back(mk("t7b", 1, 0, 0, 0, 0, 1, 5, 1, 0, 0));
    vecs.push_back(mk("t7c", 1, 0, 0, 0, 0, 1, 4, 1, 0, 0));
    vecs.push_back(mk("pause_tick", 1, 0, 0, 0, 1, 1, 4, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk("paused_tick", 1, 0, 0, 0, 0, 1, 4, 0, 0, 0));
    vecs.push_back(mk("resume", 1, 0, 0, 1, 0, 0, 4, 1, 0, 0));
    vecs.push_back(mk("r7a", 1, 0, 0, 0, 0, 1, 3, 1, 0, 0));
    vecs.push_back(mk("r7b", 1, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    vecs.push_back(mk("r7c", 1, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk("r7_expire", 1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk("r7_buzz2", 1, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("r7_buzz3", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("r7_end", 1, 0, 0, 0, 0, 0, AUTO ? 7 : 0, AUTO, 1, 0));
    vecs.push_back(mk("load0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("start0", 1, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("z_buzz2", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("z_buzz3", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("z_end", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("done_start", 1, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("load_start9", 1, 1, 9, 1, 0, 0, 9, 0, 0, 0));
    vecs.push_back(mk("start9", 1, 0, 0, 1, 0, 0, 9, 1, 0, 0));
    vecs.push_back(mk("start_pause_run", 1, 0, 0, 1, 1, 0, 9, 0, 0, 0));
    vecs.push_back(mk("start_pause_psd", 1, 0, 0, 1, 1, 0, 9, 0, 0, 0));
    vecs.push_back(mk("resume9", 1, 0, 0, 1, 0, 0, 9, 1, 0, 0));
    vecs.push_back(mk("t9", 1, 0, 0, 0, 0, 1, 8, 1, 0, 0));
    vecs.push_back(mk("load1", 1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("start1", 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("t1_expire", 1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk("rst_in_alert", 0, 0, 0, 1, 0, 1, 30, 0, 0, 0));
    vecs.push_back(mk("post_rst", 1, 0, 0, 0, 0, 0, 30, 0, 0, 0));
    vecs.push_back(mk("load1b", 1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("start1b", 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("t1b_expire", 1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vecs.push_back(mk("load_in_alert", 1, 1, 5, 1, 0, 1, 5, 0, 0, 0));
    vecs.push_back(mk("idle_after_load", 1, 0, 0, 0, 0, 1, 5, 0, 0, 0));

    foreach (vecs[i]) apply_stimulus(vecs[i]);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Periodic alarm: two full periods from a loaded value of 2
    apply_stimulus(mk("ar_load2", 1, 1, 2, 0, 0, 0, 2, 0, 0, 0));
    apply_stimulus(mk("ar_start", 1, 0, 0, 1, 0, 0, 2, 1, 0, 0));
    apply_stimulus(mk("ar_t1", 1, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    apply_stimulus(mk("ar_t2", 1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    apply_stimulus(mk("ar_buzz2", 1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    apply_stimulus(mk("ar_buzz3", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    apply_stimulus(mk("ar_reload", 1, 0, 0, 0, 0, 0, 2, 1, 1, 0));
    apply_stimulus(mk("ar_t3", 1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    apply_stimulus(mk("ar_t4", 1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    apply_stimulus(mk("ar_clear", 1, 1, 3, 0, 0, 0, 3, 0, 0, 0));
`endif

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
